// File: rtl/muldiv_pkg.sv
// Purpose: shared opcodes, FSM state encoding and width defaults for the RV32M multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package muldiv_pkg;
   localparam int MULDIV_XLEN  = 32;
   localparam int MULDIV_CNT_W = 6;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/muldiv_special.sv
// Purpose: flags divide-by-zero and signed-overflow divides and supplies their fixed RISC-V result.
// Latency: combinational.
// Backpressure: none.
module muldiv_special
   import muldiv_pkg::*;
#(
   parameter int XLEN = MULDIV_XLEN
) (
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_val,
   input  logic [XLEN-1:0] i_rs2_val,
   output logic            o_special,
   output logic [XLEN-1:0] o_result
);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic w_is_div;
   logic w_is_rem;
   logic w_signed;
   logic w_div0;
   logic w_ovf;

   assign w_is_div = i_funct3[2];
   assign w_is_rem = i_funct3[1];
   assign w_signed = ~i_funct3[0];
   assign w_div0   = (i_rs2_val == '0);
   assign w_ovf    = w_signed && (i_rs1_val == MIN_NEG) && (i_rs2_val == '1);

   // Select the architecturally defined result for the two divide corner cases.
   always_comb begin
      o_special = 1'b0;
      o_result  = '0;
      if (w_is_div && w_div0) begin
         o_special = 1'b1;
         o_result  = w_is_rem ? i_rs1_val : '1;
      end else if (w_is_div && w_ovf) begin
         o_special = 1'b1;
         o_result  = w_is_rem ? '0 : MIN_NEG;
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// Purpose: iterative RV32M multiply/divide (radix-2 shift-add / restoring divide) feeding the register file.
// Latency: XLEN+2 cycles iterative; 1 cycle for divide special cases and, with MULDIV_FAST_MUL_EN, multiplies.
// Backpressure: none downstream; start is ignored while busy and the core stalls on busy.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = MULDIV_XLEN,
   parameter int CNT_W = MULDIV_CNT_W
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_val,
   input  logic [XLEN-1:0] i_rs2_val,
   input  logic [4:0]      i_rd_in,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd_out
);
   localparam int               AW       = 2*XLEN + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN-1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [AW-1:0]    r_acc;      // mul: {carry, product hi, multiplier/product lo}; div: {remainder, quotient}
   logic [XLEN-1:0]  r_opnd;     // multiplicand or divisor magnitude
   logic [2:0]       r_f3;
   logic             r_neg_q;    // negate product / quotient
   logic             r_neg_r;    // negate remainder
   logic [XLEN-1:0]  r_result;
   logic [4:0]       r_rd;

   logic             w_accept;
   logic             w_is_div;
   logic             w_a_signed;
   logic             w_b_signed;
   logic             w_sa;
   logic             w_sb;
   logic [XLEN-1:0]  w_mag_a;
   logic [XLEN-1:0]  w_mag_b;
   logic             w_special;
   logic [XLEN-1:0]  w_spec_res;
   logic             w_short;
   logic [XLEN:0]    w_sum;
   logic [XLEN:0]    w_rem_sh;
   logic [XLEN:0]    w_trial;
   logic [AW-1:0]    w_acc_step;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]  w_quo;
   logic [XLEN-1:0]  w_rem;
   logic [XLEN-1:0]  w_fix_res;

   muldiv_special #(.XLEN(XLEN)) u_special (
      .i_funct3  (i_funct3),
      .i_rs1_val (i_rs1_val),
      .i_rs2_val (i_rs2_val),
      .o_special (w_special),
      .o_result  (w_spec_res)
   );

   // Operand signedness: MUL/MULHU unsigned, MULHSU signed A only, MULH and DIV/REM both signed.
   assign w_is_div   = i_funct3[2];
   assign w_a_signed = w_is_div ? ~i_funct3[0] : ((i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU));
   assign w_b_signed = w_is_div ? ~i_funct3[0] : (i_funct3 == F3_MULH);
   assign w_sa       = w_a_signed & i_rs1_val[XLEN-1];
   assign w_sb       = w_b_signed & i_rs2_val[XLEN-1];
   assign w_mag_a    = w_sa ? -i_rs1_val : i_rs1_val;
   assign w_mag_b    = w_sb ? -i_rs2_val : i_rs2_val;
   assign w_accept   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef MULDIV_FAST_MUL_EN
   // Sign-extended operands; the low 2*XLEN bits of their product equal the signed 33x33 product.
   logic [2*XLEN-1:0] w_fa;
   logic [2*XLEN-1:0] w_fb;
   logic [2*XLEN-1:0] w_fprod;
   logic [XLEN-1:0]   w_fast_res;
   assign w_fa       = {{XLEN{w_sa}}, i_rs1_val};
   assign w_fb       = {{XLEN{w_sb}}, i_rs2_val};
   assign w_fprod    = w_fa * w_fb;
   assign w_fast_res = (i_funct3 == F3_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
   assign w_short    = w_special | ~w_is_div;
`else
   assign w_short    = w_special;
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode and status outputs.
   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            o_done = (r_state == ST_DONE);
            if (w_accept) w_state_nxt = w_short ? ST_DONE : ST_RUN;
            else          w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            o_busy = 1'b1;
            if (r_cnt == '0) w_state_nxt = ST_FIX;
         end
         ST_FIX: begin
            o_busy      = 1'b1;
            w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
   always_comb begin
      w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
      w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
      w_trial    = w_rem_sh - {1'b0, r_opnd};
      w_acc_step = {1'b0, r_acc[AW-1:1]};
      if (r_f3[2]) begin
         if (w_rem_sh >= {1'b0, r_opnd}) w_acc_step = {w_trial, r_acc[XLEN-2:0], 1'b1};
         else                            w_acc_step = {w_rem_sh, r_acc[XLEN-2:0], 1'b0};
      end else if (r_acc[0]) begin
         w_acc_step = {1'b0, w_sum, r_acc[XLEN-1:1]};
      end
   end

   // Sign correction and high/low word selection once the iterations finish.
   always_comb begin
      w_prod    = r_neg_q ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
      w_quo     = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
      w_rem     = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
      w_fix_res = w_rem;
      case (r_f3)
         F3_MUL:                       w_fix_res = w_prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              w_fix_res = w_quo;
         default:                      w_fix_res = w_rem;
      endcase
   end

   // Operand capture on accept, one iteration per RUN cycle, result registration.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_f3     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_rd     <= '0;
      end else if (w_accept) begin
         r_f3    <= i_funct3;
         r_rd    <= i_rd_in;
         r_neg_q <= w_sa ^ w_sb;
         r_neg_r <= w_sa;
         r_cnt   <= CNT_INIT;
         if (w_is_div) begin
            r_acc  <= {{(XLEN+1){1'b0}}, w_mag_a};
            r_opnd <= w_mag_b;
         end else begin
            r_acc  <= {{(XLEN+1){1'b0}}, w_mag_b};
            r_opnd <= w_mag_a;
         end
         if (w_special) r_result <= w_spec_res;
`ifdef MULDIV_FAST_MUL_EN
         else if (!w_is_div) r_result <= w_fast_res;
`endif
      end else if (r_state == ST_RUN) begin
         r_acc <= w_acc_step;
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end else if (r_state == ST_FIX) begin
         r_result <= w_fix_res;
      end
   end

   assign o_result = r_result;
   assign o_rd_out = r_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose: scoreboard bench for muldiv_unit: result, rd, latency, busy, special cases, mid-op start/reset, back-to-back.
// Latency: expected done cycle is modelled per op (34 iterative, 1 special / fast multiply).
// Backpressure: ops are issued only when the unit is idle or in its DONE cycle.
`timescale 1ns/1ps
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_start;
   logic [2:0]  i_funct3;
   logic [31:0] i_rs1_val;
   logic [31:0] i_rs2_val;
   logic [4:0]  i_rd_in;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;
   logic [4:0]  o_rd_out;

   always #5 i_clk = ~i_clk;

   muldiv_unit dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (i_start),
      .i_funct3  (i_funct3),
      .i_rs1_val (i_rs1_val),
      .i_rs2_val (i_rs2_val),
      .i_rd_in   (i_rd_in),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_result  (o_result),
      .o_rd_out  (o_rd_out)
   );

`ifdef MULDIV_FAST_MUL_EN
   localparam int LAT_MUL = 1;
`else
   localparam int LAT_MUL = 34;
`endif

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } vec_t;

   vec_t vecs [0:12] = '{
      '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{F3_DIVU,   32'd100,       32'd7,         32'd14},
      '{F3_REMU,   32'd100,       32'd7,         32'd2},
      '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF},
      '{F3_REMU,   32'd5,         32'd0,         32'd5},
      '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
      '{F3_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF},
      '{F3_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9}
   };

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   busy_n;
   int   done_n;
   logic got_done;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      model_res = '0;
      case (f3)
         F3_MUL:    begin p = ua * ub; model_res = p[31:0];  end
         F3_MULH:   begin p = sa * sb; model_res = p[63:32]; end
         F3_MULHSU: begin p = sa * ub; model_res = p[63:32]; end
         F3_MULHU:  begin p = ua * ub; model_res = p[63:32]; end
         F3_DIV:
            if (b == 0) model_res = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_res = 32'h8000_0000;
            else model_res = $signed(a) / $signed(b);
         F3_REM:
            if (b == 0) model_res = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_res = 32'd0;
            else model_res = $signed(a) % $signed(b);
         F3_DIVU: model_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: model_res = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2]) begin
         if (b == 0) return 1;
         if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
         return 34;
      end
      return LAT_MUL;
   endfunction

   function automatic logic [31:0] pick_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Drive one request (caller is away from the clock edge), push its expectation, then scramble inputs.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res);
      exp_t e;
      e.res = exp_res;
      e.rd  = rd;
      e.cyc = cyc + model_lat(f3, a, b);
      exp_q.push_back(e);
      i_start   = 1'b1;
      i_funct3  = f3;
      i_rs1_val = a;
      i_rs2_val = b;
      i_rd_in   = rd;
      @(posedge i_clk);
      #1;
      i_start   = 1'b0;
      i_funct3  = 3'($urandom);
      i_rs1_val = $urandom;
      i_rs2_val = $urandom;
      i_rd_in   = 5'($urandom);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge i_clk);
         #2;
         n++;
      end
      if (exp_q.size() != 0) begin
         check_val("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      @(posedge i_clk);
      #1;
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge i_clk) begin
      if (i_rst_n && o_done) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_done", 32'(o_done), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_val("result", o_result, mon_e.res);
            check_val("rd_out", 32'(o_rd_out), 32'(mon_e.rd));
            check_val("done_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n   = 1'b0;
      i_start   = 1'b0;
      i_funct3  = 3'd0;
      i_rs1_val = 32'd0;
      i_rs2_val = 32'd0;
      i_rd_in   = 5'd0;
      @(posedge i_clk);
      #1;
      check_val("rst_busy",   32'(o_busy),   32'd0);
      check_val("rst_done",   32'(o_done),   32'd0);
      check_val("rst_result", o_result,      32'd0);
      check_val("rst_rd_out", 32'(o_rd_out), 32'd0);
      repeat (2) @(negedge i_clk);
      #1 i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // MUL 7 * -3: busy must stay high for every cycle before done.
      issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
      busy_n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge i_clk);
         if (o_done) break;
         if (o_busy) busy_n++;
      end
      check_val("mul_busy_cycles", busy_n, LAT_MUL - 1);
      drain(100);

      // Directed high-word, signed/unsigned divide and special-case vectors.
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 2), vecs[i].e);
         drain(100);
      end

      // Back-to-back: second start lands in the DONE cycle of the first op.
      issue(F3_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
      got_done = 1'b0;
      for (int k = 0; k < 100 && !got_done; k++) begin
         @(negedge i_clk);
         got_done = o_done;
      end
      check_val("b2b_first_done_seen", 32'(got_done), 32'd1);
      #1;
      issue(F3_REMU, 32'd100, 32'd7, 5'd3, 32'd2);
      drain(100);

      // A start 5 cycles into RUN must be ignored (a special divide would otherwise finish early).
      issue(F3_DIV, 32'h8765_4321, 32'h0000_1234, 5'd9, model_res(F3_DIV, 32'h8765_4321, 32'h0000_1234));
      repeat (5) @(posedge i_clk);
      #1;
      check_val("busy_before_ignored_start", 32'(o_busy), 32'd1);
      i_start   = 1'b1;
      i_funct3  = F3_DIVU;
      i_rs1_val = 32'd5;
      i_rs2_val = 32'd0;
      i_rd_in   = 5'd30;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      drain(100);

      // Random operations checked against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = pick_opnd();
         b  = pick_opnd();
         issue(f3, a, b, 5'($urandom), model_res(f3, a, b));
         drain(100);
      end

      // Back-to-back into REMU 100/7 left result=2, rd=3; reset 10 cycles into RUN must clear everything.
      issue(F3_REMU, 32'd100, 32'd7, 5'd3, 32'd2);
      drain(100);
      issue(F3_DIVU, 32'hDEAD_BEEF, 32'h0000_0013, 5'd12, 32'd0);
      repeat (10) @(posedge i_clk);
      #1 i_rst_n = 1'b0;
      #1;
      check_val("midrst_busy",   32'(o_busy),   32'd0);
      check_val("midrst_done",   32'(o_done),   32'd0);
      check_val("midrst_result", o_result,      32'd0);
      check_val("midrst_rd_out", 32'(o_rd_out), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge i_clk);
      #1 i_rst_n = 1'b1;
      done_n = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge i_clk);
         if (o_done) done_n++;
      end
      check_val("post_reset_done_pulses", done_n, 0);

      // Unit still works after the aborted operation.
      issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE);
      drain(100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
